xor_fault_monitor: RTL and testbench
====================================

// Module: xor_fault_monitor
// PURPOSE
// - Stimulus driver and checker for the laser-targeted 6-input XOR gate: drives a[5:0]/osc_en, samples returned q, compares to ^a.
// - Counts and reports each mismatch (laser-induced fault) over a valid/ready event port to the host logger.
// - Locate mode holds osc_en=1 (clock on input 0, photon emission) with checking disabled.
// PARAMETERS
// - SETTLE_CYCLES  4   cycles between driving a and sampling q (>=1)
// - CNT_W          16  width of fault counter and iteration counter
// PORTS
// - sysclk       in   1      system clock; all logic on rising edge
// - rst_n        in   1      asynchronous active-low reset
// - start        in   1      1-cycle pulse; starts a run when IDLE, ignored otherwise
// - abort        in   1      returns FSM to IDLE next cycle, outputs to reset values
// - mode         in   2      00 hold, 01 sweep, 10 locate, 11 reserved (treated as hold)
// - cfg_pattern  in   6      vector in hold mode; sweep start value
// - run_len      in   CNT_W  iterations per run; 0 = run until abort
// - dut_a        out  6      drives gate inputs a[5:0]
// - dut_osc_en   out  1      drives gate osc_en
// - dut_q        in   1      gate output, asynchronous to sysclk
// - busy         out  1      high from the cycle after start until DONE
// - done         out  1      1-cycle pulse at run end
// - fault_cnt    out  CNT_W  faults this run, saturating at all-ones
// - fault_valid  out  1      fault event pending
// - fault_ready  in   1      logger accepts event when valid&&ready
// - fault_vec    out  6      dut_a value at faulting sample
// - fault_q      out  1      sampled q at faulting sample
// - fault_ovf    out  1      sticky: fault dropped while event pending; cleared on start
// BEHAVIOUR
// - Reset: dut_a=0, dut_osc_en=0, busy=0, done=0, fault_cnt=0, fault_valid=0, fault_vec=0, fault_q=0, fault_ovf=0, FSM=IDLE.
// - dut_q passes a 2-flop synchronizer (q_s); compare uses q_s only.
// - FSM: IDLE -start-> DRIVE; DRIVE (register dut_a) -> SETTLE; SETTLE waits SETTLE_CYCLES -> SAMPLE;
//   SAMPLE compares, increments iteration -> DONE if iter==run_len (run_len!=0), else DRIVE; DONE pulses done -> IDLE.
// - Locate mode: IDLE -start-> LOCATE; dut_osc_en=1, dut_a=cfg_pattern, no compare, no counting; exits only on abort.
// - Fault: in SAMPLE, q_s != ^dut_a -> fault_cnt+1 (saturates). Event valid the cycle after SAMPLE.
// - Event port: fault_vec/fault_q stable while fault_valid; fault_valid drops the cycle after valid&&ready.
//   Fault while fault_valid=1 and not accepted same cycle: counted, not captured, fault_ovf=1.
//   Fault in the same cycle as handshake: new event loaded, fault_valid stays 1.
// - Sweep: dut_a starts at cfg_pattern, +1 per iteration, 63 wraps to 0. Hold: dut_a=cfg_pattern every iteration.
// - Latency per iteration: 2+SETTLE_CYCLES cycles (DRIVE + SETTLE + SAMPLE).
// - start clears fault_cnt, fault_ovf; a pending event is not cleared.
// - abort (any state, priority over start): IDLE next cycle, no done pulse, dut_osc_en=0, dut_a=0; counters hold.
// - run_len=0: endless; iteration counter wraps silently.
// CONFIGURATION
// - FAULT_TIMESTAMP_EN defined: extra output fault_ts[31:0], free-running cycle counter (reset 0, wraps)
//   captured with fault_vec, same stability rules. Undefined: port and counter absent.
// STRUCTURE
// - Shared package xor_fi_pkg: FSM state enum (IDLE, DRIVE, SETTLE, SAMPLE, DONE, LOCATE), mode encodings, DUT_W=6.
// - Sub-module sync_2ff (2-flop synchronizer, reset 0) for dut_q.
// TESTING
// - Hold, cfg_pattern=6'b000011, run_len=10, ideal gate model -> 10 iterations, done once, fault_cnt=0, fault_valid never 1.
// - Sweep, cfg_pattern=62, run_len=4 -> dut_a sequence 62,63,0,1; done after 4*(2+SETTLE_CYCLES)+1 cycles.
// - Model flips q on iteration 3, ready=1 -> fault_cnt=1, fault_vec=pattern of iteration 3, fault_q=~parity.
// - ready=0, flips on iterations 2 and 4 -> fault_cnt=2, fault_vec=iteration 2 data, fault_ovf=1; ready=1 drops valid.
// - Locate mode, abort after 50 cycles -> dut_osc_en=1 throughout, fault_cnt unchanged, IDLE and osc_en=0 next cycle.
// - rst_n asserted mid-SETTLE -> all outputs to reset values immediately, asynchronously.

Source files
------------

// File: rtl/xor_fi_pkg.sv
// Shared types for the XOR fault-injection monitor: FSM states, mode encodings,
// gate width and the parity helper that forms the expected gate output.
package xor_fi_pkg;

   localparam int DUT_W = 6;

   typedef enum logic [2:0] {
      IDLE,
      DRIVE,
      SETTLE,
      SAMPLE,
      DONE,
      LOCATE
   } state_t;

   // Reserved encoding behaves like hold.
   typedef enum logic [1:0] {
      MODE_HOLD   = 2'b00,
      MODE_SWEEP  = 2'b01,
      MODE_LOCATE = 2'b10,
      MODE_RSVD   = 2'b11
   } mode_t;

   function automatic logic parity(input logic [DUT_W-1:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/xor_fault_monitor_sync.sv
// Two-flop synchronizer, both stages reset to 0, for bringing the gate output
// into the sysclk domain.
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/xor_fault_monitor.sv
// Stimulus driver and checker for the laser-targeted 6-input XOR gate, with a
// valid/ready fault event port. Define FAULT_TIMESTAMP_EN to add fault_ts.
module xor_fault_monitor
   import xor_fi_pkg::*;
#(
   parameter int SETTLE_CYCLES = 4,
   parameter int CNT_W         = 16
) (
   input  logic             sysclk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       mode,
   input  logic [DUT_W-1:0] cfg_pattern,
   input  logic [CNT_W-1:0] run_len,
   output logic [DUT_W-1:0] dut_a,
   output logic             dut_osc_en,
   input  logic             dut_q,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] fault_cnt,
   output logic             fault_valid,
   input  logic             fault_ready,
   output logic [DUT_W-1:0] fault_vec,
   output logic             fault_q,
   output logic             fault_ovf
`ifdef FAULT_TIMESTAMP_EN
   ,
   output logic [31:0]      fault_ts
`endif
);

   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

   state_t           state;
   state_t           state_nxt;
   logic             q_s;
   logic [SW-1:0]    settle_cnt;
   logic [CNT_W-1:0] iter;
   logic [CNT_W-1:0] iter_inc;
   logic [CNT_W-1:0] len_r;
   logic             sweep_r;
   logic [DUT_W-1:0] pat;
   logic             start_acc;
   logic             fault;
   logic             handshake;
   logic             load_evt;

   sync_2ff u_sync (
      .clk   (sysclk),
      .rst_n (rst_n),
      .d     (dut_q),
      .q     (q_s)
   );

   assign iter_inc  = iter + CNT_W'(1);
   assign start_acc = (state == IDLE) && start && !abort;
   assign fault     = (state == SAMPLE) && !abort && (q_s != parity(dut_a));
   assign handshake = fault_valid && fault_ready;
   assign load_evt  = fault && (!fault_valid || fault_ready);

   assign busy = (state == DRIVE) || (state == SETTLE) ||
                 (state == SAMPLE) || (state == LOCATE);
   assign done = (state == DONE);

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = (mode == MODE_LOCATE) ? LOCATE : DRIVE;
         DRIVE:   state_nxt = SETTLE;
         SETTLE:  if (settle_cnt == SETTLE_LAST) state_nxt = SAMPLE;
         SAMPLE:  state_nxt = ((len_r != '0) && (iter_inc == len_r)) ? DONE : DRIVE;
         DONE:    state_nxt = IDLE;
         LOCATE:  state_nxt = LOCATE;
         default: state_nxt = IDLE;
      endcase
      if (abort) state_nxt = IDLE;
   end

   // Run configuration is latched at start; hold mode follows cfg_pattern live.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         dut_a      <= '0;
         dut_osc_en <= 1'b0;
         settle_cnt <= '0;
         iter       <= '0;
         len_r      <= '0;
         sweep_r    <= 1'b0;
         pat        <= '0;
      end else if (abort) begin
         dut_a      <= '0;
         dut_osc_en <= 1'b0;
         settle_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  len_r      <= run_len;
                  sweep_r    <= (mode == MODE_SWEEP);
                  pat        <= cfg_pattern;
                  iter       <= '0;
                  settle_cnt <= '0;
                  if (mode == MODE_LOCATE) begin
                     dut_osc_en <= 1'b1;
                     dut_a      <= cfg_pattern;
                  end
               end
            end
            DRIVE: begin
               dut_a      <= sweep_r ? pat : cfg_pattern;
               settle_cnt <= '0;
            end
            SETTLE:  settle_cnt <= settle_cnt + SW'(1);
            SAMPLE: begin
               iter <= iter_inc;
               pat  <= pat + DUT_W'(1);
            end
            LOCATE:  dut_a <= cfg_pattern;
            default: ;
         endcase
      end
   end

   // A fault that cannot be captured is still counted but flags overflow.
   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         fault_cnt   <= '0;
         fault_valid <= 1'b0;
         fault_vec   <= '0;
         fault_q     <= 1'b0;
         fault_ovf   <= 1'b0;
      end else begin
         if (start_acc) begin
            fault_cnt <= '0;
            fault_ovf <= 1'b0;
         end else if (fault && (fault_cnt != '1)) begin
            fault_cnt <= fault_cnt + CNT_W'(1);
         end

         if (load_evt) begin
            fault_valid <= 1'b1;
            fault_vec   <= dut_a;
            fault_q     <= q_s;
         end else begin
            if (fault)     fault_ovf   <= 1'b1;
            if (handshake) fault_valid <= 1'b0;
         end
      end
   end

`ifdef FAULT_TIMESTAMP_EN
   logic [31:0] ts_cnt;

   always_ff @(posedge sysclk or negedge rst_n) begin
      if (!rst_n) begin
         ts_cnt   <= '0;
         fault_ts <= '0;
      end else begin
         ts_cnt <= ts_cnt + 32'd1;
         if (load_evt) fault_ts <= ts_cnt;
      end
   end
`endif

endmodule

// File: tb/tb_xor_fault_monitor.sv
// Self-checking bench for xor_fault_monitor: ideal XOR gate with per-iteration
// fault injection, checked against a run-level model of the event port.
module tb_xor_fault_monitor;
   import xor_fi_pkg::*;

   localparam int SETTLE = 4;
   localparam int CNT_W  = 16;
   localparam int P      = SETTLE + 2;

   logic             sysclk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic             abort = 1'b0;
   logic [1:0]       mode = 2'b00;
   logic [5:0]       cfg_pattern = '0;
   logic [CNT_W-1:0] run_len = '0;
   logic [5:0]       dut_a;
   logic             dut_osc_en;
   logic             dut_q;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] fault_cnt;
   logic             fault_valid;
   logic             fault_ready = 1'b0;
   logic [5:0]       fault_vec;
   logic             fault_q;
   logic             fault_ovf;
   logic             flip = 1'b0;
`ifdef FAULT_TIMESTAMP_EN
   logic [31:0]      fault_ts;
`endif

   int compared   = 0;
   int mismatched = 0;

   // Event-port model carried across runs: a pending event survives start.
   bit         m_pending = 0;
   logic [5:0] m_vec = '0;
   logic       m_q = 1'b0;
   bit         valid_seen = 0;

   xor_fault_monitor #(.SETTLE_CYCLES(SETTLE), .CNT_W(CNT_W)) dut (
      .sysclk      (sysclk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .mode        (mode),
      .cfg_pattern (cfg_pattern),
      .run_len     (run_len),
      .dut_a       (dut_a),
      .dut_osc_en  (dut_osc_en),
      .dut_q       (dut_q),
      .busy        (busy),
      .done        (done),
      .fault_cnt   (fault_cnt),
      .fault_valid (fault_valid),
      .fault_ready (fault_ready),
      .fault_vec   (fault_vec),
      .fault_q     (fault_q),
      .fault_ovf   (fault_ovf)
`ifdef FAULT_TIMESTAMP_EN
      ,
      .fault_ts    (fault_ts)
`endif
   );

   always #5 sysclk = ~sysclk;

   assign dut_q = (^dut_a) ^ flip;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // One complete run; mask bit k flips the gate output during iteration k.
   task automatic applyStimulus(input logic [1:0] md, input logic [5:0] cfg, input int len,
                                input logic [15:0] mask, input logic rdy);
      int         faults;
      int         done_cnt;
      int         k;
      bit         exp_ovf;
      logic [5:0] a_k;

      mode        = md;
      cfg_pattern = cfg;
      run_len     = CNT_W'(len);
      fault_ready = rdy;
      flip        = 1'b0;
      valid_seen  = 0;

      faults  = 0;
      exp_ovf = 0;
      if (rdy) m_pending = 0;
      for (int i = 0; i < len; i++) begin
         a_k = (md == MODE_SWEEP) ? 6'(int'(cfg) + i) : cfg;
         if (mask[i]) begin
            faults++;
            if (rdy || !m_pending) begin
               m_vec     = a_k;
               m_q       = ~(^a_k);
               m_pending = !rdy;
            end else begin
               exp_ovf = 1;
            end
         end
      end

      @(posedge sysclk); #1;
      start = 1'b1;
      @(posedge sysclk); #1;
      start = 1'b0;

      done_cnt = 0;
      for (int n = 1; n <= len * P + 2; n++) begin
         k    = (n - 1) / P;
         flip = (k < len) ? mask[k] : 1'b0;
         if (fault_valid) valid_seen = 1;
         done_cnt += int'(done);
         if (n == 1) checkOutput("busy_after_start", 32'(busy), 32'd1);
         if (k < len && ((n - 1) % P) == 1) begin
            a_k = (md == MODE_SWEEP) ? 6'(int'(cfg) + k) : cfg;
            checkOutput($sformatf("dut_a_iter%0d", k), 32'(dut_a), 32'(a_k));
         end
         if (n == len * P + 1) checkOutput("done_latency", 32'(done), 32'd1);
         if (n < len * P + 2) begin
            @(posedge sysclk); #1;
         end
      end

      checkOutput("done_pulses", 32'(done_cnt), 32'd1);
      checkOutput("busy_idle", 32'(busy), 32'd0);
      checkOutput("fault_cnt", 32'(fault_cnt), 32'(faults));
      checkOutput("fault_valid", 32'(fault_valid), 32'(m_pending));
      checkOutput("fault_vec", 32'(fault_vec), 32'(m_vec));
      checkOutput("fault_q", 32'(fault_q), 32'(m_q));
      checkOutput("fault_ovf", 32'(fault_ovf), 32'(exp_ovf));
   endtask

   initial begin
      logic [1:0]  md;
      logic [5:0]  loc_cfg;
      int          pick;

      repeat (3) @(posedge sysclk);
      #1;
      checkOutput("reset_dut_a", 32'(dut_a), 32'd0);
      checkOutput("reset_osc_en", 32'(dut_osc_en), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(done), 32'd0);
      checkOutput("reset_fault_cnt", 32'(fault_cnt), 32'd0);
      checkOutput("reset_fault_valid", 32'(fault_valid), 32'd0);
      rst_n = 1'b1;

      applyStimulus(MODE_HOLD, 6'b000011, 10, 16'h0000, 1'b1);
      checkOutput("hold_valid_never", 32'(valid_seen), 32'd0);

      applyStimulus(MODE_SWEEP, 6'd62, 4, 16'h0000, 1'b1);

      applyStimulus(MODE_SWEEP, 6'($urandom), 5, 16'b0000_0100, 1'b1);

      applyStimulus(MODE_HOLD, 6'($urandom), 5, 16'b0000_1010, 1'b0);
      fault_ready = 1'b1;
      @(posedge sysclk); #1;
      m_pending = 0;
      checkOutput("ready_drops_valid", 32'(fault_valid), 32'd0);
      checkOutput("ovf_sticky", 32'(fault_ovf), 32'd1);

      for (int r = 0; r < 8; r++) begin
         pick = int'($urandom_range(0, 2));
         md   = (pick == 0) ? MODE_HOLD : (pick == 1) ? MODE_SWEEP : MODE_RSVD;
         applyStimulus(md, 6'($urandom), int'($urandom_range(1, 8)),
                       16'($urandom), 1'($urandom));
      end

      // Leave an event pending so locate and reset have non-trivial state.
      applyStimulus(MODE_HOLD, 6'h2A, 1, 16'h0001, 1'b0);

      loc_cfg     = 6'($urandom);
      mode        = MODE_LOCATE;
      cfg_pattern = loc_cfg;
      @(posedge sysclk); #1;
      start = 1'b1;
      @(posedge sysclk); #1;
      start = 1'b0;
      checkOutput("locate_dut_a", 32'(dut_a), 32'(loc_cfg));
      for (int n = 0; n < 50; n++) begin
         checkOutput($sformatf("locate_osc_en_%0d", n), 32'(dut_osc_en), 32'd1);
         @(posedge sysclk); #1;
      end
      abort = 1'b1;
      @(posedge sysclk); #1;
      abort = 1'b0;
      checkOutput("abort_osc_en", 32'(dut_osc_en), 32'd0);
      checkOutput("abort_dut_a", 32'(dut_a), 32'd0);
      checkOutput("abort_busy", 32'(busy), 32'd0);
      checkOutput("abort_done", 32'(done), 32'd0);
      checkOutput("locate_fault_cnt", 32'(fault_cnt), 32'd0);
      checkOutput("locate_fault_valid", 32'(fault_valid), 32'(m_pending));
      checkOutput("locate_fault_vec", 32'(fault_vec), 32'(m_vec));

      mode        = MODE_HOLD;
      cfg_pattern = 6'h2A;
      run_len     = CNT_W'(5);
      @(posedge sysclk); #1;
      start = 1'b1;
      @(posedge sysclk); #1;
      start = 1'b0;
      repeat (2) @(posedge sysclk);
      #3;
      checkOutput("pre_reset_dut_a", 32'(dut_a), 32'h2A);
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_dut_a", 32'(dut_a), 32'd0);
      checkOutput("async_rst_osc_en", 32'(dut_osc_en), 32'd0);
      checkOutput("async_rst_busy", 32'(busy), 32'd0);
      checkOutput("async_rst_done", 32'(done), 32'd0);
      checkOutput("async_rst_fault_cnt", 32'(fault_cnt), 32'd0);
      checkOutput("async_rst_fault_valid", 32'(fault_valid), 32'd0);
      checkOutput("async_rst_fault_vec", 32'(fault_vec), 32'd0);
      checkOutput("async_rst_fault_q", 32'(fault_q), 32'd0);
      checkOutput("async_rst_fault_ovf", 32'(fault_ovf), 32'd0);
      m_pending = 0;
      m_vec     = '0;
      m_q       = 1'b0;
      repeat (2) @(posedge sysclk);
      #1;
      rst_n = 1'b1;

      applyStimulus(MODE_SWEEP, 6'($urandom), 3, 16'b0000_0001, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
